fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of the PC logic; owns the fetch address, starting at RESET_PC and advancing by 4 per issued request.
Issues word requests to instruction memory over a valid/ready request channel and accepts in-order responses.
Buffers returned words with their PCs in a small queue and presents them to decode over a valid/ready handshake.
Supports redirect (branch/jump): flushes queued words and drops stale in-flight responses.

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Owns the fetch PC (starting at RESET_PC) and issues word requests to
// instruction memory under a credit limit of DEPTH: requests in flight plus
// words buffered can never exceed DEPTH. In-order responses are paired with
// their request PC, buffered, and presented to decode. A redirect reloads the
// fetch PC, flushes the buffer and marks every in-flight response as stale.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem_req_*        request channel to instruction memory (valid/ready, addr)
//   imem_rsp_*        in-order response words from memory (no backpressure)
//   redirect_*        branch/jump redirect with new fetch address
//   if_*              instruction channel to decode (valid/ready, pc, instr)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ibuf_entry_t;

    // Fetch address and bookkeeping counters
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_q, drop_d;

    // In-flight PC FIFO (one entry per accepted request)
    logic [31:0]   pcf_q [DEPTH];
    logic [31:0]   pcf_d [DEPTH];
    logic [AW-1:0] pcf_wr_q, pcf_wr_d;
    logic [AW-1:0] pcf_rd_q, pcf_rd_d;

    // Instruction buffer towards decode
    ibuf_entry_t   ibuf_q [DEPTH];
    ibuf_entry_t   ibuf_d [DEPTH];
    logic [AW-1:0] ib_wr_q, ib_wr_d;
    logic [AW-1:0] ib_rd_q, ib_rd_d;
    logic [CW-1:0] ib_cnt_q, ib_cnt_d;

    logic          pop_c;
    logic          req_fire_c;
    logic          rsp_fire_c;
    logic          rsp_keep_c;
    logic [SW-1:0] credit_used_c;

    // Handshakes and credit; a word leaving to decode this cycle frees its
    // slot immediately so a latency-1 memory sustains one instruction/cycle.
    always_comb begin
        if_valid       = (ib_cnt_q != '0);
        if_pc          = ibuf_q[ib_rd_q].pc;
        if_instr       = ibuf_q[ib_rd_q].instr;
        imem_req_addr  = fetch_pc_q;
        pop_c          = if_valid && if_ready && !redirect_valid;
        credit_used_c  = SW'(out_cnt_q) + SW'(ib_cnt_q) - SW'(pop_c);
        imem_req_valid = !rst && !redirect_valid && (credit_used_c < SW'(DEPTH));
        req_fire_c     = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored
        rsp_fire_c     = imem_rsp_valid && (out_cnt_q != '0);
        rsp_keep_c     = rsp_fire_c && (drop_q == '0) && !redirect_valid;
    end

    // Next-state computation
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_cnt_d  = out_cnt_q;
        drop_d     = drop_q;
        pcf_d      = pcf_q;
        pcf_wr_d   = pcf_wr_q;
        pcf_rd_d   = pcf_rd_q;
        ibuf_d     = ibuf_q;
        ib_wr_d    = ib_wr_q;
        ib_rd_d    = ib_rd_q;
        ib_cnt_d   = ib_cnt_q;

        if (req_fire_c) begin
            pcf_d[pcf_wr_q] = fetch_pc_q;
            pcf_wr_d        = pcf_wr_q + AW'(1);
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end

        if (rsp_fire_c) begin
            pcf_rd_d = pcf_rd_q + AW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end

        out_cnt_d = out_cnt_q + CW'(req_fire_c) - CW'(rsp_fire_c);

        if (redirect_valid) begin
            // Everything still in flight after this cycle is stale
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            drop_d     = out_cnt_d;
            ib_cnt_d   = '0;
            ib_rd_d    = ib_wr_q;
        end else begin
            if (rsp_keep_c) begin
                ibuf_d[ib_wr_q] = '{pc: pcf_q[pcf_rd_q], instr: imem_rsp_data};
                ib_wr_d         = ib_wr_q + AW'(1);
            end
            if (pop_c) begin
                ib_rd_d = ib_rd_q + AW'(1);
            end
            ib_cnt_d = ib_cnt_q + CW'(rsp_keep_c) - CW'(pop_c);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= '0;
            drop_q     <= '0;
            pcf_q      <= '{default: '0};
            pcf_wr_q   <= '0;
            pcf_rd_q   <= '0;
            ibuf_q     <= '{default: '0};
            ib_wr_q    <= '0;
            ib_rd_q    <= '0;
            ib_cnt_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_q     <= drop_d;
            pcf_q      <= pcf_d;
            pcf_wr_q   <= pcf_wr_d;
            pcf_rd_q   <= pcf_rd_d;
            ibuf_q     <= ibuf_d;
            ib_wr_q    <= ib_wr_d;
            ib_rd_q    <= ib_rd_d;
            ib_cnt_q   <= ib_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: memory model with variable latency, randomized
// handshakes and redirects, and a scoreboard of expected (pc, instr) pairs
// derived from the architectural fetch stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int unsigned due; logic [31:0] addr; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mreq_t       mem_q[$];
    exp_t        sb[$];
    logic [31:0] model_pc;
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int unsigned lat = 1;
    int unsigned rdy_pct = 100, ifr_pct = 100, redir_pct = 0;
    bit          redir_req = 0;
    logic [31:0] redir_tgt = '0;
    int          total = 0, bad = 0;
    int          n_req = 0, n_deliv = 0;

    // Memory image: any fixed scramble of the address
    function automatic logic [31:0] memfn(input logic [31:0] a);
        logic [31:0] r;
        r = {a[15:0], a[31:16]};
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
    endtask

    // One clock: advance, then drive memory response and random handshakes
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        if_ready       = ($urandom_range(99) < ifr_pct);
        if (redir_req) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_req      = 1'b0;
        end else if ($urandom_range(99) < redir_pct) begin
            redirect_valid = 1'b1;
            if ($urandom_range(9) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else redirect_pc = 32'($urandom_range(4095));
        end else begin
            redirect_valid = 1'b0;
        end
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redir_req = 1'b1;
        redir_tgt = t;
        step();
    endtask

    // Stimulus side: reference fetch stream, memory acceptance, protocol checks
    logic        prev_stall, prev_redir, prev_hold;
    logic [31:0] prev_addr, prev_pc, prev_instr;
    int unsigned d;
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mem_q.delete();
            model_pc   = 32'h0000_0000;
            prev_stall = 1'b0;
            prev_redir = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (prev_stall) chk("req_addr_stable", imem_req_addr, prev_addr);
            if (prev_redir) chk("flush_after_redirect", 32'(if_valid), 32'd0);
            if (prev_hold) begin
                chk("if_valid_held", 32'(if_valid), 32'd1);
                chk("if_pc_held", if_pc, prev_pc);
                chk("if_instr_held", if_instr, prev_instr);
            end
            if (redirect_valid) begin
                chk("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
                sb.delete();
                model_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, model_pc);
                sb.push_back('{pc: model_pc, instr: memfn(model_pc)});
                model_pc = model_pc + 32'd4;
            end
            if (imem_req_valid && imem_req_ready) begin
                n_req++;
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mem_q.push_back('{due: d, addr: imem_req_addr});
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
            prev_redir = redirect_valid;
            prev_hold  = if_valid && !if_ready && !redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end
    end

    // Monitor: compare every delivered instruction against the scoreboard
    exp_t e;
    always @(negedge clk) begin
        if (!rst && !redirect_valid && if_valid && if_ready) begin
            n_deliv++;
            if (sb.size() == 0) begin
                chk("unexpected_delivery", if_pc, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                chk("if_pc", if_pc, e.pc);
                chk("if_instr", if_instr, e.instr);
            end
        end
    end

    int r0, d0;
    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        step();
        step();
        @(negedge clk);
        chk_reset();
        step();
        rst = 1'b0;

        // Streaming at latency 1: one instruction per cycle
        repeat (3) step();
        d0 = n_deliv;
        repeat (20) step();
        chk("throughput", 32'(n_deliv - d0), 32'd20);

        // Decode stalled: only DEPTH requests, head held
        ifr_pct = 0;
        redirect_to(32'h0);
        r0 = n_req;
        repeat (10) step();
        @(negedge clk);
        chk("stall_req_count", 32'(n_req - r0), 32'd2);
        chk("stall_if_valid", 32'(if_valid), 32'd1);
        chk("stall_if_pc", if_pc, 32'h0);
        ifr_pct = 100;
        repeat (10) step();

        // Memory not ready for three cycles
        rdy_pct = 0;
        redirect_to(32'h0);
        repeat (3) step();
        @(negedge clk);
        chk("mem_stall_addr", imem_req_addr, 32'h0);
        chk("mem_stall_valid", 32'(imem_req_valid), 32'd1);
        rdy_pct = 100;
        repeat (10) step();

        // Latency 3 with requests in flight, then redirect
        lat = 3;
        repeat (10) step();
        redirect_to(32'h100);
        repeat (15) step();

        // Misaligned redirect target
        redirect_to(32'h203);
        step();
        @(negedge clk);
        chk("misaligned_req_addr", imem_req_addr, 32'h200);
        repeat (10) step();

        // Redirect colliding with decode handshake and a response
        lat = 1;
        repeat (12) step();
        redir_req = 1'b1;
        redir_tgt = 32'h300;
        step();
        @(negedge clk);
        chk("collide_setup", 32'(imem_rsp_valid && if_valid && if_ready), 32'd1);
        repeat (10) step();

        // Reset mid-operation
        lat = 2;
        repeat (5) step();
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk_reset();
        step();
        rst = 1'b0;
        repeat (10) step();

        // Randomized operation
        d0 = n_deliv;
        redir_pct = 3;
        for (int b = 0; b < 10; b++) begin
            lat     = $urandom_range(1, 4);
            rdy_pct = $urandom_range(60, 100);
            ifr_pct = $urandom_range(50, 100);
            repeat (200) step();
        end
        redir_pct = 0;
        rdy_pct = 100;
        ifr_pct = 100;
        repeat (20) step();
        @(negedge clk);
        chk("random_progress", 32'(n_deliv - d0 > 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
